menu_cursor: RTL and testbench

- Battle-menu cursor navigator and the producer side of the menu command interface.
- Turns raw direction and select buttons into the cursor coordinate bus (x, y) and the single-cycle enter strobe that the command filter decodes into a one-hot command.
- Tracks one of six legal slots:
  - row 0: (88,22), (128,22)
  - row 1: (8,62), (48,62), (88,62), (128,62)
- Emits enter only on a legal slot, then locks out input so one press yields exactly one command.

---
 rtl/menu_cursor_if.sv | 24 ++
 rtl/menu_cursor.sv | 145 ++++++++++++++
 tb/tb_menu_cursor.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/menu_cursor_if.sv
// Button inputs and cursor/command outputs of the battle-menu cursor.
// The master side drives the buttons; the slave side (menu_cursor) produces the cursor bus.
interface menu_cursor_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_up;
  logic       btn_down;
  logic       btn_select;
  logic [9:0] x;
  logic [8:0] y;
  logic       enter;
  logic [2:0] slot;
  logic       busy;

  modport master (
    output btn_left, btn_right, btn_up, btn_down, btn_select,
    input  x, y, enter, slot, busy
  );

  modport slave (
    input  btn_left, btn_right, btn_up, btn_down, btn_select,
    output x, y, enter, slot, busy
  );
endinterface

// File: rtl/menu_cursor.sv
// Battle-menu cursor: synchronized button edges move a saturating 6-slot cursor, select emits one enter then locks out.
// Optional MENU_CURSOR_AUTOREPEAT_EN adds hold-to-repeat for a single held direction.
module menu_cursor #(
  parameter int LOCK_CYCLES   = 16
`ifdef MENU_CURSOR_AUTOREPEAT_EN
  , parameter int HOLD_CYCLES   = 5000000
  , parameter int REPEAT_CYCLES = 2500000
`endif
) (
  input  logic          clk,
  input  logic          reset,
  menu_cursor_if.slave  bus
);
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CONFIRM, LOCKOUT} state_t;

  // Button bit order: 0 right, 1 left, 2 down, 3 up, 4 select
  logic [4:0]    w_btn;
  logic [4:0]    r_sync1, r_sync2, r_prev;
  logic [4:0]    w_evt;
  logic [3:0]    w_dir;
  logic [3:0]    w_rpt;
  logic [2:0]    w_nslot;
  state_t        r_state;
  logic [LW-1:0] r_cnt;
  logic [2:0]    r_slot;
  logic [9:0]    r_x;
  logic [8:0]    r_y;
  logic          r_enter;

  assign w_btn = {bus.btn_select, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
  assign w_evt = r_sync2 & ~r_prev;
  assign w_dir = w_evt[3:0] | w_rpt;

  function automatic logic [9:0] map_x(input logic [2:0] s);
    case (s)
      3'd0: map_x = 10'd88;
      3'd1: map_x = 10'd128;
      3'd3: map_x = 10'd48;
      3'd4: map_x = 10'd88;
      3'd5: map_x = 10'd128;
      default: map_x = 10'd8;
    endcase
  endfunction

  function automatic logic [8:0] map_y(input logic [2:0] s);
    map_y = (s == 3'd0 || s == 3'd1) ? 9'd22 : 9'd62;
  endfunction

  // Saturating moves; priority up > down > left > right
  always_comb begin
    w_nslot = r_slot;
    if (w_dir[3]) begin
      if (r_slot == 3'd4) w_nslot = 3'd0;
      else if (r_slot == 3'd5) w_nslot = 3'd1;
    end else if (w_dir[2]) begin
      if (r_slot == 3'd0) w_nslot = 3'd4;
      else if (r_slot == 3'd1) w_nslot = 3'd5;
    end else if (w_dir[1]) begin
      if (r_slot == 3'd1 || r_slot == 3'd3 || r_slot == 3'd4 || r_slot == 3'd5)
        w_nslot = r_slot - 3'd1;
    end else if (w_dir[0]) begin
      if (r_slot == 3'd0 || r_slot == 3'd2 || r_slot == 3'd3 || r_slot == 3'd4)
        w_nslot = r_slot + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_slot  <= 3'd2;
      r_x     <= 10'd8;
      r_y     <= 9'd62;
      r_enter <= 1'b0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      case (r_state)
        IDLE: begin
          r_enter <= 1'b0;
          if (w_evt[4]) begin
            r_state <= CONFIRM;
            r_enter <= 1'b1;
          end else if (|w_dir) begin
            r_slot <= w_nslot;
            r_x    <= map_x(w_nslot);
            r_y    <= map_y(w_nslot);
          end
        end
        CONFIRM: begin
          r_enter <= 1'b0;
          r_cnt   <= LW'(LOCK_CYCLES - 1);
          r_state <= LOCKOUT;
        end
        LOCKOUT: begin
          r_enter <= 1'b0;
          if (r_cnt == '0) r_state <= IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        default: begin
          r_enter <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef MENU_CURSOR_AUTOREPEAT_EN
  logic [31:0] r_hold;
  logic        r_rep;
  logic        w_run;
  logic [31:0] w_lim;

  // Counter runs only while exactly one direction is held steady in IDLE
  assign w_run = (r_state == IDLE) && $onehot(r_sync2[3:0]) && !r_sync2[4] && (r_sync2 == r_prev);
  assign w_lim = r_rep ? 32'(REPEAT_CYCLES - 1) : 32'(HOLD_CYCLES - 1);
  assign w_rpt = (w_run && r_hold == w_lim) ? r_sync2[3:0] : 4'b0;

  always_ff @(posedge clk) begin
    if (reset || !w_run) begin
      r_hold <= '0;
      r_rep  <= 1'b0;
    end else if (|w_rpt) begin
      r_hold <= '0;
      r_rep  <= 1'b1;
    end else begin
      r_hold <= r_hold + 32'd1;
    end
  end
`else
  assign w_rpt = 4'b0;
`endif

  assign bus.x     = r_x;
  assign bus.y     = r_y;
  assign bus.slot  = r_slot;
  assign bus.enter = r_enter;
  assign bus.busy  = (r_state != IDLE);
endmodule

// File: tb/tb_menu_cursor.sv
// Self-checking bench for menu_cursor: expected cursor positions are queued per press and popped after the press settles.
module tb_menu_cursor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  menu_cursor_if bus();

  menu_cursor #(.LOCK_CYCLES(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct { int slot; int x; int y; string name; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Slot coordinate table from the menu layout
  int tx[6] = '{88, 128, 8, 48, 88, 128};
  int ty[6] = '{22, 22, 62, 62, 62, 62};

  int n_enter = 0, n_busy = 0, n_bb = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (bus.enter === 1'b1) n_enter++;
    if (bus.busy === 1'b1) n_busy++;
    if (bus.enter === 1'b1 && prev_en === 1'b1) n_bb++;
    prev_en = bus.enter;
  end

  localparam int B_RIGHT = 0, B_LEFT = 1, B_DOWN = 2, B_UP = 3, B_SEL = 4;

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_RIGHT: bus.btn_right  = v;
      B_LEFT:  bus.btn_left   = v;
      B_DOWN:  bus.btn_down   = v;
      B_UP:    bus.btn_up     = v;
      default: bus.btn_select = v;
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_pos(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      checks++;
      $display("FAIL %s: scoreboard empty", nm);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (bus.slot !== 3'(e.slot) || bus.x !== 10'(e.x) || bus.y !== 9'(e.y)) begin
      errors++;
      $display("FAIL %s/%s: got slot=%0d x=%0d y=%0d expected slot=%0d x=%0d y=%0d",
               nm, e.name, bus.slot, bus.x, bus.y, e.slot, e.x, e.y);
    end
  endtask

  task automatic press(input int b, input int exp_slot, input string nm);
    sb.push_back('{exp_slot, tx[exp_slot], ty[exp_slot], nm});
    @(negedge clk) set_btn(b, 1'b1);
    cycles(4);
    set_btn(b, 1'b0);
    cycles(4);
    check_pos("press");
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cycles(10);
    sb.push_back('{2, 8, 62, "reset"});
    check_pos("reset");
    checks++;
    if (bus.enter !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got enter=%b busy=%b expected 0 0", bus.enter, bus.busy);
    end
  endtask

  task automatic test_right();
    press(B_RIGHT, 3, "right1");
    press(B_RIGHT, 4, "right2");
    press(B_RIGHT, 5, "right3");
    press(B_RIGHT, 5, "right_sat");
  endtask

  task automatic test_vertical();
    press(B_UP, 1, "up_from5");
    press(B_LEFT, 0, "left_from1");
    press(B_LEFT, 0, "left_sat");
    press(B_DOWN, 4, "down_from0");
  endtask

  task automatic test_select();
    int e0, b0, bb0, w;
    do_reset();
    cycles(4);
    press(B_UP, 2, "up_blocked");
    e0 = n_enter; b0 = n_busy; bb0 = n_bb;
    @(negedge clk) bus.btn_select = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.enter !== 1'b0) begin errors++; $display("FAIL sel_k: got enter=%b expected 0", bus.enter); end
    @(negedge clk);
    checks++;
    if (bus.enter !== 1'b0) begin errors++; $display("FAIL sel_k1: got enter=%b expected 0", bus.enter); end
    @(negedge clk);
    checks++;
    if (bus.enter !== 1'b1 || bus.busy !== 1'b1 || bus.x !== 10'd8 || bus.y !== 9'd62)
      begin errors++; $display("FAIL sel_k2: got enter=%b busy=%b x=%0d y=%0d expected 1 1 8 62",
                               bus.enter, bus.busy, bus.x, bus.y); end
    cycles(37);
    bus.btn_select = 1'b0;
    w = 0;
    while (bus.busy !== 1'b0 && w < 100) begin @(negedge clk); w++; end
    cycles(10);
    checks++;
    if (n_enter - e0 != 1) begin errors++; $display("FAIL sel_enters: got %0d expected 1", n_enter - e0); end
    checks++;
    if (n_busy - b0 != 17) begin errors++; $display("FAIL sel_busy: got %0d expected 17", n_busy - b0); end
    checks++;
    if (n_bb != bb0) begin errors++; $display("FAIL sel_b2b: got %0d back-to-back enters expected 0", n_bb - bb0); end
    sb.push_back('{2, 8, 62, "after_sel"});
    check_pos("sel");
  endtask

  task automatic test_simultaneous();
    int e0;
    press(B_RIGHT, 3, "to_slot3");
    e0 = n_enter;
    sb.push_back('{3, 48, 62, "sel_left"});
    @(negedge clk) begin bus.btn_select = 1'b1; bus.btn_left = 1'b1; end
    cycles(4);
    bus.btn_select = 1'b0; bus.btn_left = 1'b0;
    cycles(26);
    checks++;
    if (n_enter - e0 != 1) begin errors++; $display("FAIL simul_enter: got %0d expected 1", n_enter - e0); end
    check_pos("simul");
  endtask

  task automatic test_reset_lockout();
    press(B_RIGHT, 4, "to4");
    press(B_RIGHT, 5, "to5");
    @(negedge clk) bus.btn_select = 1'b1;
    cycles(3);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL rl_busy: got busy=%b expected 1", bus.busy); end
    cycles(5);
    bus.btn_select = 1'b0;
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.enter !== 1'b0) begin
      errors++; $display("FAIL rl_flags: got busy=%b enter=%b expected 0 0", bus.busy, bus.enter);
    end
    sb.push_back('{2, 8, 62, "rl_slot"});
    check_pos("reset_lockout");
    press(B_RIGHT, 3, "after_rl");
  endtask

  initial begin
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_up = 1'b0;
    bus.btn_down = 1'b0; bus.btn_select = 1'b0;
    test_reset();
    test_right();
    test_vertical();
    test_select();
    test_simultaneous();
    test_reset_lockout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
